// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and elaboration-time helpers for the
//               parametrised synchronous FIFO.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package fifo_pkg;

    localparam int c_default_width = 16;
    localparam int c_default_depth = 8;

    // Smallest n with 2**n >= value; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit fifo_params_legal(
        input int width,
        input int depth,
        input int af_thresh,
        input int ae_thresh,
        input int fwft
    );
        return (width >= 1) && is_pow2(depth) &&
               (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh >= 0) && (ae_thresh <= depth - 1) &&
               ((fwft == 0) || (fwft == 1));
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_dp_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_dp_ram
// Description : Simple dual-port RAM, synchronous write, asynchronous read.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module fifo_dp_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int DEPTH = c_default_depth
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [clog2(DEPTH)-1:0]    i_waddr,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic [clog2(DEPTH)-1:0]    i_raddr,
    output logic [WIDTH-1:0]           o_rdata
);

    // Storage is deliberately left unreset.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : fifo_dp_ram
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_param
// Description : Parametrised single-clock FIFO with standard or FWFT read,
//               occupancy count, threshold flags and sticky error flags.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = c_default_width,
    parameter int DEPTH     = c_default_depth,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        data_in,
    input  logic                    we,
    input  logic                    re,
    output logic [WIDTH-1:0]        data_out,
    output logic                    data_valid,
    output logic                    fifo_full,
    output logic                    fifo_empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int c_addr_w = clog2(DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_af    = c_cnt_w'(AF_THRESH);
    localparam logic [c_cnt_w-1:0] c_ae    = c_cnt_w'(AE_THRESH);

    generate
        if (!fifo_params_legal(WIDTH, DEPTH, AF_THRESH, AE_THRESH, FWFT)) begin : g_param_check
            $error("fifo_sync_param: illegal WIDTH/DEPTH/threshold/FWFT parameter set");
        end
    endgenerate

    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_overflow;
    logic                r_underflow;
    logic                w_rd_ok;
    logic                w_wr_ok;
    logic                w_ram_we;
    logic [WIDTH-1:0]    w_ram_rdata;

    assign fifo_empty   = (r_count == '0);
    assign fifo_full    = (r_count == c_depth);
    assign almost_full  = (r_count >= c_af);
    assign almost_empty = (r_count <= c_ae);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A full FIFO still takes a write when the head leaves on the same edge.
    assign w_rd_ok  = re && !fifo_empty;
    assign w_wr_ok  = we && (!fifo_full || w_rd_ok);
    assign w_ram_we = w_wr_ok && !rst && !flush;

    fifo_dp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            if (we && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end
            if (re && !w_rd_ok) begin
                r_underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out   = fifo_empty ? '0 : w_ram_rdata;
            assign data_valid = !fifo_empty;
        end else begin : g_std
            logic [WIDTH-1:0] r_data_out;
            logic             r_data_valid;

            // Flush drops the valid strobe but leaves the last word visible.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data_out   <= '0;
                    r_data_valid <= 1'b0;
                end else if (flush) begin
                    r_data_valid <= 1'b0;
                end else begin
                    r_data_valid <= w_rd_ok;
                    if (w_rd_ok) begin
                        r_data_out <= w_ram_rdata;
                    end
                end
            end

            assign data_out   = r_data_out;
            assign data_valid = r_data_valid;
        end
    endgenerate

endmodule : fifo_sync_param
`default_nettype wire

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised single-clock synchronous FIFO. Next generation of the team's 16-bit x 8 FIFO.
- Adds:
  - configurable width and depth;
  - selectable standard or first-word-fall-through (FWFT) read mode;
  - occupancy count and almost-full/almost-empty thresholds;
  - sticky overflow/underflow flags and a synchronous flush.
- Sits between producer and consumer datapaths in the same clock domain.

Parameters:
- width, 16, data word width in bits (>=1).
- depth, 8, number of entries; power of two, >=2.
- af_thresh, depth-2, almost_full asserts when count >= af_thresh (1..depth).
- ae_thresh, 1, almost_empty asserts when count <= ae_thresh (0..depth-1).
- fwft, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  rising-edge clock; all state updates on it.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous clear of contents, pointers and count; flags below.
- data_in  in  width  write data.
- we  in  1  write request.
- re  in  1  read request (fwft=1: acknowledge/pop of head word).
- data_out  out  width  read data.
- data_valid  out  1  fwft=0: data_out holds a word popped the previous cycle; fwft=1: equals !fifo_empty.
- fifo_full  out  1  count == depth.
- fifo_empty  out  1  count == 0.
- almost_full  out  1  count >= af_thresh.
- almost_empty  out  1  count <= ae_thresh.
- count  out  clog2(depth)+1  current occupancy, 0..depth.
- overflow  out  1  sticky; a write was rejected.
- underflow  out  1  sticky; a read was rejected.

Behaviour:
- Reset: sampled only on the clk edge when rst=1. rst has priority over flush, we and re.
- Reset values:
  - pointers = 0, count = 0, data_out = 0, data_valid = 0;
  - fifo_empty = 1, fifo_full = 0, almost_empty = 1, almost_full = 0;
  - overflow = 0, underflow = 0.
- Memory contents are not reset.
- Accept rules, evaluated per edge:
  - rd_ok = re && !fifo_empty.
  - wr_ok = we && (!fifo_full || rd_ok). A write at full is accepted when a read is accepted on the same edge.
  - A read at empty is never accepted, even with a simultaneous write (no bypass).
- Pointers: rd_ptr/wr_ptr are clog2(depth) bits and wrap naturally modulo depth.
- Count update: count += wr_ok - rd_ok. If both are accepted, count is unchanged.
- Flags: all flags are decoded combinationally from the registered count, so they change only after a clock edge.
- Standard mode (fwft=0):
  - On rd_ok, data_out <= mem[rd_ptr] and data_valid <= 1 on the same edge (one-cycle latency).
  - Otherwise data_valid <= 0 and data_out holds its last value.
- FWFT mode (fwft=1):
  - data_out = mem[rd_ptr] whenever !fifo_empty; data_out = 0 when empty.
  - re pops the head; the next word appears after the same edge.
- Sticky error flags:
  - overflow <= 1 on any edge with we && !wr_ok.
  - underflow <= 1 on any edge with re && !rd_ok.
  - Cleared only by rst or flush.
- flush (when rst=0):
  - Next edge: pointers = 0, count = 0, data_valid = 0, overflow = 0, underflow = 0.
  - we and re on that edge are ignored.
  - data_out is unchanged in mode 0 and goes to 0 in mode 1.
- Reset or flush mid-burst: all in-flight data is discarded. The first write after release lands at address 0.
- Write/read data ordering is strict FIFO across pointer wrap-around.

Decomposition:
- Shared include/package fifo_pkg:
  - clog2 constant function;
  - default width/depth constants;
  - parameter-legality checks (depth power of two, threshold ranges) that error at elaboration.
- One natural sub-module, fifo_dp_ram: simple dual-port RAM, width x depth.
  - Synchronous write.
  - Asynchronous read port. fifo_sync_param registers the read output in mode 0.
- Pointer, count, flag and error logic stay in fifo_sync_param.

Test Plan:
- Defaults (fwft=0), after rst: write 1..8 on 8 consecutive edges -> count 1..8; almost_full at count 6; fifo_full after the 8th edge. A 9th write of 9 -> overflow=1, count stays 8.
- Read 8 words -> data_out 1,2,...,8, each with data_valid=1 one cycle after re; fifo_empty after the 8th edge. A 9th read -> underflow=1, data_valid=0, data_out holds 8.
- At full, assert we=1 (data 9) and re=1 together -> count stays 8, no overflow, data_out=1. Draining then yields 2..8, 9.
- Wrap-around: write 1..5, read 5, write 10..17, read 8 -> outputs 1..5 then 10..17 in order; count returns to 0.
- fwft=1: write 7 -> data_out=7 and data_valid=1 the cycle after the write with no re. re pops it -> fifo_empty=1, data_out=0.
- Mid-operation: with 4 entries and overflow=1, flush=1 -> count=0, overflow=0, fifo_empty=1; the next write of 0xABCD reads back as 0xABCD. Repeat the same sequence with rst=1 alongside flush -> all outputs return to their reset values.
